rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one 8-input resource between eight requesters, built around the team's 8-to-3 priority encoder function. Each cycle in which arbitration is open, it picks one active request, starting the search just after the last winner, and holds that grant until the owner drops its request or a hold limit expires. It sits in front of any shared datapath that needs one-hot ownership plus a 3-bit owner index.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant. Legal range is 2..255.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 8: level request per requester. A requester holds its bit high for as long as it wants ownership.
- `gnt` output 8: registered one-hot grant. It is all-zero when no one owns the resource.
- `gnt_id` output 3: binary index of the current owner. It is 0 when `gnt_vld`=0.
- `gnt_vld` output 1: high while any grant is asserted. It equals the OR of `gnt`.
- `preempt` output 1: one-cycle pulse in the first cycle of RELEASE when that release was forced by `MAX_HOLD`.

## Operation
- Reset values: state IDLE, `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `preempt`=0, pointer `ptr`=0, `hold_cnt`=0.
- Arbitration function:
  - Rotate `req` right by `ptr`.
  - Priority-encode the result, with the lowest set bit winning.
  - The winner is (encoded + `ptr`) mod 8, using 3-bit wrap-around arithmetic.
  - No active `req` means no winner.
- State IDLE:
  - Outputs are zero.
  - If any `req` is set, go to GRANT and load `gnt`/`gnt_id` with the winner.
  - Otherwise stay in IDLE.
- State GRANT:
  - `gnt` is held constant, and `hold_cnt` increments every cycle.
  - If `req[gnt_id]`=0, go to RELEASE with `preempt`=0.
  - Else, if `hold_cnt`=`MAX_HOLD`-1, go to RELEASE with `preempt`=1.
  - If both conditions are true in the same cycle, the voluntary release wins and `preempt`=0.
- State RELEASE:
  - Lasts exactly one cycle, with `gnt`=0 and `gnt_vld`=0 (the dead cycle).
  - If any `req` is set, go to GRANT and arbitrate exactly as from IDLE.
  - Otherwise go to IDLE.
- Pointer update: on every transition into GRANT, `ptr` <= winner+1 (mod 8). The pointer is unchanged otherwise.
  - A preempted owner that keeps requesting therefore ranks lowest on the next arbitration.
- `hold_cnt` clears on entry to GRANT. It is 8 bits wide and never exceeds `MAX_HOLD`-1.
- Requests from non-owners during GRANT are ignored until RELEASE. No mid-grant switch is allowed.
- `req` bits are sampled only at the clock edge. No combinational path runs from `req` to any output.

## Timing
- Grant latency from IDLE: `req` sampled high at edge N gives `gnt` high after edge N.
- Voluntary release:
  - Owner `req` low at edge N gives `gnt`=0 after edge N.
  - The next grant appears after edge N+1 at the earliest, because of the single dead cycle.
- Forced release: the owner holds `gnt` for exactly `MAX_HOLD` cycles, then RELEASE begins with `preempt`=1 for that one cycle.
- Back-to-back ownership: with continuous contention, each grant period is followed by exactly one RELEASE cycle.
- Reset mid-operation:
  - Asserting `rst_n`=0 clears all outputs immediately (asynchronous), independent of `clk`.
  - Deassertion is synchronised by the integrator. After deassertion, the first arbitration uses `ptr`=0.
- Wrap-around: with `ptr`=7, bit 7 is checked first, then bits 0, 1 and so on.

## Test plan
- Reset: drive `rst_n`=0 mid-GRANT, with `gnt`=8'b0000_0100.
  - `gnt`, `gnt_id`, `gnt_vld` and `preempt` must go to 0 immediately.
  - After release, `req`=8'hFF must give `gnt`=8'b0000_0001.
- Single requester: `req`=8'b0100_0000 for 5 cycles, then 0.
  - Required: `gnt`=8'b0100_0000, `gnt_id`=6, held 5 cycles.
  - Then 1 dead cycle, then IDLE.
- Round-robin: `req`=8'hFF held, with each owner dropping its bit for 1 cycle after 2 cycles of ownership.
  - Required grant order: ids 0,1,2,...,7,0, each separated by one RELEASE cycle.
- Wrap-around: take a grant to id 7, so `ptr`=0. Then present `req`=8'b1000_0001.
  - Required: id 0 is granted, then id 7 next.
  - Separately, with `ptr`=6 and `req`=8'b0000_0011, id 0 wins.
- Preemption: `MAX_HOLD`=4, with `req`=8'b0000_0110 held constant.
  - Required: id 1 for 4 cycles, then `preempt`=1 for one cycle.
  - Then id 2 for 4 cycles, `preempt`, then id 1.
- Simultaneous events: owner id 3 drops `req` exactly at `hold_cnt`=`MAX_HOLD`-1.
  - Required: RELEASE with `preempt`=0.
  - Non-owner requests asserted during GRANT do not change `gnt` until RELEASE.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, an owner index,
// a per-owner hold limit and a single dead cycle between consecutive owners.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  output logic [7:0] o_gnt,
  output logic [2:0] o_gnt_id,
  output logic       o_gnt_vld,
  output logic       o_preempt
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_REL} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_id;
  logic       r_gnt_vld;
  logic       r_preempt;
  logic [2:0] r_ptr;
  logic [7:0] r_hold_cnt;

  logic [7:0] w_rot;
  logic [2:0] w_enc;
  logic [2:0] w_win;
  logic       w_any;
  logic       w_owner_req;

  // Lowest set bit wins; an all-zero input encodes to 0 and is qualified by w_any.
  function automatic logic [2:0] pri_enc8(input logic [7:0] v);
    pri_enc8 = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) pri_enc8 = 3'(i);
  endfunction

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < 8; i++)
      w_rot[i] = i_req[3'(i) + r_ptr];
  end

  assign w_enc       = pri_enc8(w_rot);
  assign w_win       = w_enc + r_ptr;
  assign w_any       = |i_req;
  assign w_owner_req = i_req[r_gnt_id];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_gnt_vld  <= 1'b0;
      r_preempt  <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_REL: begin
          r_preempt <= 1'b0;
          if (w_any) begin
            r_state    <= S_GRANT;
            r_gnt      <= 8'd1 << w_win;
            r_gnt_id   <= w_win;
            r_gnt_vld  <= 1'b1;
            r_ptr      <= w_win + 3'd1;
            r_hold_cnt <= '0;
          end else begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_gnt_vld <= 1'b0;
          end
        end
        S_GRANT: begin
          // A voluntary drop takes precedence over the hold limit.
          if (!w_owner_req || r_hold_cnt == HOLD_LAST) begin
            r_state    <= S_REL;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_gnt_vld  <= 1'b0;
            r_preempt  <= w_owner_req;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_gnt     <= '0;
          r_gnt_id  <= '0;
          r_gnt_vld <= 1'b0;
          r_preempt <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_id  = r_gnt_id;
  assign o_gnt_vld = r_gnt_vld;
  assign o_preempt = r_preempt;

  a_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_gnt));
  a_vld:    assert property (@(posedge i_clk) disable iff (!i_rst_n) r_gnt_vld == (|r_gnt));
  a_hold:   assert property (@(posedge i_clk) disable iff (!i_rst_n) r_hold_cnt <= HOLD_LAST);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: one default-limit instance and one with MAX_HOLD=4.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0, req_p = '0;
  logic [7:0] gnt, gnt_p;
  logic [2:0] gnt_id, gnt_id_p;
  logic       gnt_vld, gnt_vld_p, preempt, preempt_p;
  logic [12:0] obs, obs_p;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  rr_arbiter8 dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .o_gnt(gnt), .o_gnt_id(gnt_id), .o_gnt_vld(gnt_vld), .o_preempt(preempt)
  );

  rr_arbiter8 #(.MAX_HOLD(4)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_p),
    .o_gnt(gnt_p), .o_gnt_id(gnt_id_p), .o_gnt_vld(gnt_vld_p), .o_preempt(preempt_p)
  );

  // {gnt, gnt_id, gnt_vld, preempt}
  assign obs   = {gnt, gnt_id, gnt_vld, preempt};
  assign obs_p = {gnt_p, gnt_id_p, gnt_vld_p, preempt_p};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    req_p = '0;
    #3;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    n_chk++; if (obs !== 13'h0) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs, 13'h0); end
    n_chk++; if (obs_p !== 13'h0) begin n_fail++; $display("FAIL reset_idle_p: got %h want %h", obs_p, 13'h0); end
    req = 8'b0000_0100;
    tick();
    n_chk++; if (obs !== {8'h04, 3'd2, 2'b10}) begin n_fail++; $display("FAIL reset_pre_gnt: got %h want %h", obs, {8'h04, 3'd2, 2'b10}); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (obs !== 13'h0) begin n_fail++; $display("FAIL reset_async: got %h want %h", obs, 13'h0); end
    req = 8'hFF;
    #2 rst_n = 1'b1;
    tick();
    n_chk++; if (obs !== {8'h01, 3'd0, 2'b10}) begin n_fail++; $display("FAIL reset_first_arb: got %h want %h", obs, {8'h01, 3'd0, 2'b10}); end
  endtask

  task automatic test_single;
    do_reset();
    req = 8'b0100_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (obs !== {8'h40, 3'd6, 2'b10}) begin n_fail++; $display("FAIL single_hold_%0d: got %h want %h", i, obs, {8'h40, 3'd6, 2'b10}); end
    end
    req = '0;
    tick();
    n_chk++; if (obs !== 13'h0) begin n_fail++; $display("FAIL single_dead: got %h want %h", obs, 13'h0); end
    tick();
    n_chk++; if (obs !== 13'h0) begin n_fail++; $display("FAIL single_idle: got %h want %h", obs, 13'h0); end
  endtask

  task automatic test_round_robin;
    logic [7:0]  oh;
    logic [12:0] e;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      oh = 8'd1 << (k % 8);
      e  = {oh, 3'(k % 8), 2'b10};
      tick();
      n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rr_grant_%0d: got %h want %h", k, obs, e); end
      tick();
      n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rr_hold_%0d: got %h want %h", k, obs, e); end
      req = 8'hFF & ~oh;
      tick();
      n_chk++; if (obs !== 13'h0) begin n_fail++; $display("FAIL rr_dead_%0d: got %h want %h", k, obs, 13'h0); end
      req = 8'hFF;
    end
  endtask

  task automatic test_wrap;
    do_reset();
    req = 8'h80;
    tick();
    n_chk++; if (obs !== {8'h80, 3'd7, 2'b10}) begin n_fail++; $display("FAIL wrap_id7: got %h want %h", obs, {8'h80, 3'd7, 2'b10}); end
    req = '0;
    tick();
    req = 8'b1000_0001;
    tick();
    n_chk++; if (obs !== {8'h01, 3'd0, 2'b10}) begin n_fail++; $display("FAIL wrap_ptr0: got %h want %h", obs, {8'h01, 3'd0, 2'b10}); end
    req = 8'h80;
    tick();
    n_chk++; if (obs !== 13'h0) begin n_fail++; $display("FAIL wrap_dead: got %h want %h", obs, 13'h0); end
    req = 8'b1000_0001;
    tick();
    n_chk++; if (obs !== {8'h80, 3'd7, 2'b10}) begin n_fail++; $display("FAIL wrap_next7: got %h want %h", obs, {8'h80, 3'd7, 2'b10}); end
    req = '0;
    tick();
    req = 8'h20;
    tick();
    n_chk++; if (obs !== {8'h20, 3'd5, 2'b10}) begin n_fail++; $display("FAIL wrap_id5: got %h want %h", obs, {8'h20, 3'd5, 2'b10}); end
    req = '0;
    tick();
    req = 8'b0000_0011;
    tick();
    n_chk++; if (obs !== {8'h01, 3'd0, 2'b10}) begin n_fail++; $display("FAIL wrap_ptr6: got %h want %h", obs, {8'h01, 3'd0, 2'b10}); end
  endtask

  task automatic test_preempt;
    do_reset();
    req_p = 8'b0000_0110;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (obs_p !== {8'h02, 3'd1, 2'b10}) begin n_fail++; $display("FAIL pre_id1_%0d: got %h want %h", i, obs_p, {8'h02, 3'd1, 2'b10}); end
    end
    tick();
    n_chk++; if (obs_p !== 13'h1) begin n_fail++; $display("FAIL pre_pulse1: got %h want %h", obs_p, 13'h1); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (obs_p !== {8'h04, 3'd2, 2'b10}) begin n_fail++; $display("FAIL pre_id2_%0d: got %h want %h", i, obs_p, {8'h04, 3'd2, 2'b10}); end
    end
    tick();
    n_chk++; if (obs_p !== 13'h1) begin n_fail++; $display("FAIL pre_pulse2: got %h want %h", obs_p, 13'h1); end
    tick();
    n_chk++; if (obs_p !== {8'h02, 3'd1, 2'b10}) begin n_fail++; $display("FAIL pre_back_id1: got %h want %h", obs_p, {8'h02, 3'd1, 2'b10}); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    req_p = 8'h08;
    tick();
    n_chk++; if (obs_p !== {8'h08, 3'd3, 2'b10}) begin n_fail++; $display("FAIL sim_grant: got %h want %h", obs_p, {8'h08, 3'd3, 2'b10}); end
    req_p = 8'h09;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (obs_p !== {8'h08, 3'd3, 2'b10}) begin n_fail++; $display("FAIL sim_no_switch_%0d: got %h want %h", i, obs_p, {8'h08, 3'd3, 2'b10}); end
    end
    req_p = 8'h01;
    tick();
    n_chk++; if (obs_p !== 13'h0) begin n_fail++; $display("FAIL sim_voluntary: got %h want %h", obs_p, 13'h0); end
    tick();
    n_chk++; if (obs_p !== {8'h01, 3'd0, 2'b10}) begin n_fail++; $display("FAIL sim_next: got %h want %h", obs_p, {8'h01, 3'd0, 2'b10}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_preempt();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
